// File: rtl/param_parallel_pe_if.sv
// param_parallel_pe_if: beat input and group result bundle of param_parallel_pe.
// master drives beats and reads results; slave is the PE itself.
interface param_parallel_pe_if #(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int ACCW  = 32
) ();
    logic [LANES*DW-1:0] neuron;
    logic [LANES*DW-1:0] weight;
    logic [1:0]          ctl;
    logic                vld_i;
    logic [ACCW-1:0]     result;
    logic                vld_o;
    logic                seq_err;
    logic                ovf;

    modport master (
        output neuron, weight, ctl, vld_i,
        input  result, vld_o, seq_err, ovf
    );

    modport slave (
        input  neuron, weight, ctl, vld_i,
        output result, vld_o, seq_err, ovf
    );
endinterface

// File: rtl/param_parallel_pe.sv
// param_parallel_pe: LANES-wide signed MAC, 3-stage pipe, ctl-framed groups.
// Define PE_SAT_EN for saturating tree sum/accumulate and the ovf flag.
module param_parallel_pe #(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int ACCW  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    param_parallel_pe_if.slave  bus
);
    localparam int PW = 2 * DW;
    localparam int SW = PW + $clog2(LANES);

    typedef enum logic {IDLE, ACC} state_t;

    state_t                 state;
    logic signed [PW-1:0]   prod [LANES];
    logic                   v1;
    logic                   v2;
    logic [1:0]             c1;
    logic [1:0]             c2;
    logic signed [SW-1:0]   tree;
    logic signed [SW-1:0]   sum2;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_nxt;
    logic signed [ACCW-1:0] base;
    logic signed [ACCW-1:0] tr;
    logic [ACCW-1:0]        result_q;
    logic                   vld_q;
    logic                   err_q;
    logic                   start;
    logic                   err;
    logic                   emit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            c1 <= '0;
            for (int i = 0; i < LANES; i++) prod[i] <= '0;
        end else begin
            v1 <= bus.vld_i;
            c1 <= bus.ctl;
            if (bus.vld_i) begin
                for (int i = 0; i < LANES; i++) begin
                    prod[i] <= PW'($signed(bus.neuron[i*DW +: DW]))
                             * PW'($signed(bus.weight[i*DW +: DW]));
                end
            end
        end
    end

    // Binary adder tree: leaves at LANES..2*LANES-1, root at node 1.
    always_comb begin : tree_add
        logic signed [SW-1:0] node [2*LANES];
        for (int i = 0; i < 2 * LANES; i++) node[i] = '0;
        for (int i = 0; i < LANES; i++) node[LANES+i] = SW'(prod[i]);
        for (int i = LANES - 1; i >= 1; i--) node[i] = node[2*i] + node[2*i+1];
        tree = node[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            c2   <= '0;
            sum2 <= '0;
        end else begin
            v2   <= v1;
            c2   <= c1;
            sum2 <= tree;
        end
    end

    always_comb begin
        tr    = ACCW'(sum2);
        start = (state == IDLE) || c2[0];
        err   = (state == IDLE) ? !c2[0] : c2[0];
        emit  = c2[1];
        base  = start ? '0 : acc;
    end

`ifdef PE_SAT_EN
    localparam int XW = (SW > ACCW) ? SW : ACCW;
    localparam logic signed [ACCW-1:0] AMAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] AMIN = {1'b1, {(ACCW-1){1'b0}}};

    logic signed [XW-1:0]   sx;
    logic signed [XW-1:0]   back;
    logic signed [ACCW-1:0] sumc;
    logic signed [ACCW:0]   full;
    logic                   clamp;
    logic                   add_ovf;
    logic                   ovf_q;

    // A tree sum that does not survive the round trip through ACCW is clamped.
    always_comb begin
        sx      = XW'(sum2);
        back    = XW'(tr);
        clamp   = (sx != back);
        sumc    = clamp ? (sx[XW-1] ? AMIN : AMAX) : tr;
        full    = {base[ACCW-1], base} + {sumc[ACCW-1], sumc};
        add_ovf = (full[ACCW] != full[ACCW-1]);
        acc_nxt = add_ovf ? (full[ACCW] ? AMIN : AMAX) : full[ACCW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (v2) begin
            ovf_q <= (start ? 1'b0 : ovf_q) | clamp | add_ovf;
        end
    end

    assign bus.ovf = ovf_q;
`else
    always_comb acc_nxt = base + tr;

    assign bus.ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            result_q <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            vld_q <= v2 && emit;
            err_q <= v2 && err;
            if (v2) begin
                acc   <= acc_nxt;
                state <= emit ? IDLE : ACC;
                if (emit) result_q <= acc_nxt;
            end
        end
    end

    assign bus.result  = result_q;
    assign bus.vld_o   = vld_q;
    assign bus.seq_err = err_q;
endmodule

// File: tb/tb_param_parallel_pe.sv
// tb_param_parallel_pe: directed vector table plus randomized beats
// checked against an exact-arithmetic group model.
module tb_param_parallel_pe;
    localparam int LANES = 32;
    localparam int DW    = 16;
    localparam int ACCW  = 32;
    localparam int VW    = LANES * DW;

    localparam bit [1:0] MID   = 2'd0;
    localparam bit [1:0] FIRST = 2'd1;
    localparam bit [1:0] LAST  = 2'd2;
    localparam bit [1:0] ONLY  = 2'd3;

    localparam longint AMAX = 64'sd2147483647;
    localparam longint AMIN = -64'sd2147483648;

`ifdef PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        bit        v;
        bit [1:0]  c;
        int        nv;
        int        wv;
        int        nl;
        bit        ev;
        bit [31:0] er;
        bit        ee;
        bit        eo;
    } row_t;

    typedef struct {
        bit        v;
        bit [31:0] r;
        bit        e;
        bit        o;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    row_t tbl[$];
    exp_t q[$];

    bit     m_grp;
    longint m_acc;
    bit [31:0] m_res;
    bit     m_ovf;

    param_parallel_pe_if #(.LANES(LANES), .DW(DW), .ACCW(ACCW)) bus ();

    param_parallel_pe #(.LANES(LANES), .DW(DW), .ACCW(ACCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] fill(input int v, input int nl);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < nl; i++) r[i*DW +: DW] = v[15:0];
        return r;
    endfunction

    function automatic logic [VW-1:0] rvec(input int mode);
        logic [VW-1:0] r;
        logic [15:0]   x;
        for (int i = 0; i < LANES; i++) begin
            case (mode)
                0: x = 16'($urandom);
                1: x = 16'($urandom_range(0, 15)) - 16'd8;
                default: x = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
            endcase
            r[i*DW +: DW] = x;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_grp = 1'b0;
        m_acc = 0;
        m_res = '0;
        m_ovf = 1'b0;
        q.delete();
        q.push_back('{v: 1'b0, r: 32'd0, e: 1'b0, o: 1'b0});
        q.push_back('{v: 1'b0, r: 32'd0, e: 1'b0, o: 1'b0});
    endtask

    // Group semantics with exact 64-bit arithmetic, then range rules.
    task automatic model_step(input bit v, input bit [1:0] c,
                              input logic [VW-1:0] n, input logic [VW-1:0] w,
                              output exp_t e);
        longint s;
        longint t;
        bit     clamp;
        bit     st;
        e.v = 1'b0;
        e.e = 1'b0;
        if (v) begin
            s = 0;
            for (int i = 0; i < LANES; i++)
                s += longint'($signed(n[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
            clamp = 1'b0;
            t = s;
            if (SAT) begin
                if (s > AMAX) begin t = AMAX; clamp = 1'b1; end
                else if (s < AMIN) begin t = AMIN; clamp = 1'b1; end
            end else begin
                t = longint'(int'(s));
            end
            st  = !m_grp || c[0];
            e.e = m_grp ? c[0] : !c[0];
            if (st) begin
                m_acc = t;
                m_ovf = clamp;
            end else begin
                m_acc += t;
                if (SAT) begin
                    if (m_acc > AMAX) begin m_acc = AMAX; m_ovf = 1'b1; end
                    else if (m_acc < AMIN) begin m_acc = AMIN; m_ovf = 1'b1; end
                    m_ovf |= clamp;
                end else begin
                    m_acc = longint'(int'(m_acc));
                end
            end
            if (c[1]) begin
                e.v   = 1'b1;
                m_res = 32'(m_acc);
                m_grp = 1'b0;
            end else begin
                m_grp = 1'b1;
            end
        end
        e.r = m_res;
        e.o = m_ovf;
    endtask

    task automatic cycle(input bit v, input bit [1:0] c,
                         input logic [VW-1:0] n, input logic [VW-1:0] w);
        exp_t e;
        exp_t o;
        bus.vld_i  = v;
        bus.ctl    = c;
        bus.neuron = n;
        bus.weight = w;
        @(posedge clk);
        #1;
        model_step(v, c, n, w, e);
        q.push_back(e);
        if (q.size() > 2) begin
            o = q.pop_front();
            check("mdl_vld_o", 32'(bus.vld_o), 32'(o.v));
            check("mdl_result", bus.result, o.r);
            check("mdl_seq_err", 32'(bus.seq_err), 32'(o.e));
            check("mdl_ovf", 32'(bus.ovf), 32'(o.o));
        end
    endtask

    task automatic add(input bit v, input bit [1:0] c, input int nv, input int wv,
                       input int nl, input bit ev, input bit [31:0] er,
                       input bit ee, input bit eo);
        tbl.push_back('{v: v, c: c, nv: nv, wv: wv, nl: nl,
                        ev: ev, er: er, ee: ee, eo: eo});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_result"}, bus.result, 32'd0);
        check({tag, "_vld_o"}, 32'(bus.vld_o), 32'd0);
        check({tag, "_seq_err"}, 32'(bus.seq_err), 32'd0);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    endtask

    initial begin
        int mode;
        row_t r;
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        bus.vld_i  = 1'b0;
        bus.ctl    = 2'd0;
        bus.neuron = '0;
        bus.weight = '0;

        // Group of 4 beats, 64 each.
        add(1, FIRST, 1, 2, 32, 0, 32'd0, 0, 0);
        add(1, MID,   1, 2, 32, 0, 32'd0, 0, 0);
        add(1, MID,   1, 2, 32, 0, 32'd0, 0, 0);
        add(1, LAST,  1, 2, 32, 1, 32'd256, 0, 0);
        // Single-beat negative group.
        add(1, ONLY, -3, 5, 1, 1, 32'hFFFF_FFF1, 0, 0);
        // Bubbles carry garbage that must be ignored.
        add(1, FIRST, 2, 5, 1, 0, 32'hFFFF_FFF1, 0, 0);
        add(0, ONLY, 99, 99, 32, 0, 32'hFFFF_FFF1, 0, 0);
        add(0, MID, -7, 3, 32, 0, 32'hFFFF_FFF1, 0, 0);
        add(1, LAST, 2, 5, 1, 1, 32'd20, 0, 0);
        add(1, ONLY, 7, 1, 1, 1, 32'd7, 0, 0);
        // Framing errors.
        add(1, MID,   5, 1, 1, 0, 32'd7, 1, 0);
        add(1, LAST,  6, 1, 1, 1, 32'd11, 0, 0);
        add(1, FIRST, 3, 1, 1, 0, 32'd11, 0, 0);
        add(1, FIRST, 4, 1, 1, 0, 32'd11, 1, 0);
        add(1, LAST,  1, 1, 1, 1, 32'd5, 0, 0);
        // Full-scale products: clamp or wrap.
        add(1, FIRST, 32'h7FFF, 32'h7FFF, 32, 0, 32'd5, 0, SAT);
        add(1, MID,   32'h7FFF, 32'h7FFF, 32, 0, 32'd5, 0, SAT);
        add(1, MID,   32'h7FFF, 32'h7FFF, 32, 0, 32'd5, 0, SAT);
        add(1, LAST,  32'h7FFF, 32'h7FFF, 32, 1,
            SAT ? 32'h7FFF_FFFF : 32'hFF80_0080, 0, SAT);

        #12;
        check_reset("rst_init");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < tbl.size() + 2; i++) begin
            if (i < tbl.size()) begin
                r = tbl[i];
                cycle(r.v, r.c, fill(r.nv, r.nl), fill(r.wv, r.nl));
            end else begin
                cycle(1'b0, MID, '0, '0);
            end
            if (i >= 2) begin
                r = tbl[i-2];
                check($sformatf("dir%0d_vld_o", i - 2), 32'(bus.vld_o), 32'(r.ev));
                check($sformatf("dir%0d_result", i - 2), bus.result, r.er);
                check($sformatf("dir%0d_seq_err", i - 2), 32'(bus.seq_err), 32'(r.ee));
                check($sformatf("dir%0d_ovf", i - 2), 32'(bus.ovf), 32'(r.eo));
            end
        end

        for (int i = 0; i < 400; i++) begin
            mode = $urandom_range(0, 2);
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  rvec(mode), rvec(mode));
        end

        // Make sure result is nonzero, then reset with a LAST beat in flight.
        cycle(1'b1, ONLY, fill(3, 4), fill(5, 4));
        cycle(1'b0, MID, '0, '0);
        cycle(1'b0, MID, '0, '0);
        cycle(1'b1, FIRST, fill(2, 8), fill(2, 8));
        cycle(1'b1, LAST, fill(2, 8), fill(2, 8));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_async");
        bus.vld_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, MID, '0, '0);
        cycle(1'b1, ONLY, fill(-4, 2), fill(4, 2));
        cycle(1'b0, MID, '0, '0);
        cycle(1'b0, MID, '0, '0);
        check("post_rst_result", bus.result, 32'hFFFF_FFE0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
